// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI4-Stream FIFO with optional store-and-forward packet mode, counters and threshold flags
module axis_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter bit PACKET_MODE = 1'b0,
  parameter int AF_THRESH = (1 << ADDR_WIDTH) - 16,
  parameter int AE_THRESH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic                  re_en,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic [ADDR_WIDTH:0]   pkt_count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] full_lvl = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] af_lvl = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] ae_lvl = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] cnt_one = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ptr_one = ADDR_WIDTH'(1);
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic wr, hs, rel, load, pkt_in, pkt_out;
  assign s_axis_tready = wr_en && !full;
  assign wr = s_axis_tvalid && s_axis_tready;
  assign hs = m_axis_tvalid && m_axis_tready;
  // the full term lets a packet longer than the memory drain instead of deadlocking
  assign rel = PACKET_MODE ? (pkt_count != '0 || full) : 1'b1;
  assign load = data_count != '0 && re_en && (!m_axis_tvalid || hs) && rel;
  assign pkt_in = wr && s_axis_tlast;
  assign pkt_out = hs && m_axis_tlast;
  assign full = data_count == full_lvl;
  assign empty = data_count == '0 && !m_axis_tvalid;
  assign almost_full = data_count >= af_lvl;
  assign almost_empty = data_count <= ae_lvl;
  // storage array, no reset so it maps onto block RAM
  always_ff @(posedge aclk)
    if (wr) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  // pointers, occupancy and packet counters
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_count <= '0;
      pkt_count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + ptr_one;
      if (load) rd_ptr <= rd_ptr + ptr_one;
      if (wr != load) data_count <= wr ? data_count + cnt_one : data_count - cnt_one;
      if (pkt_in != pkt_out) pkt_count <= pkt_in ? pkt_count + cnt_one : pkt_count - cnt_one;
    end
  // output register: refill on load, otherwise hold until the handshake retires it
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
      m_axis_tvalid <= 1'b1;
    end else if (hs) m_axis_tvalid <= 1'b0;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: scoreboard bench for stream and packet-mode fifo instances
module tb_axis_pkt_fifo;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;
  localparam int AF = DEPTH - 16;
  localparam int AE = 16;
  localparam int BOUND = 20000;
  logic clk = 1'b0;
  logic aresetn;
  logic wr_en [2], re_en [2], sl [2], sv [2], sr [2], ml [2], mv [2], mr [2];
  logic full [2], empty [2], af [2], ae [2];
  logic [DW-1:0] sd [2], md [2];
  logic [AW:0] dc [2], pc [2];
  int checks = 0, errors = 0;
  int hs_cnt [2];
  bit acc [2], p_mv [2], p_hs [2], p_ld [2], p_stall [2];
  logic [DW:0] p_out [2];
  int plast [2];
  logic [DW:0] q [2][$];

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_MODE(1'b0)) u0 (
    .aclk(clk), .aresetn(aresetn), .wr_en(wr_en[0]), .re_en(re_en[0]),
    .s_axis_tdata(sd[0]), .s_axis_tlast(sl[0]), .s_axis_tvalid(sv[0]), .s_axis_tready(sr[0]),
    .m_axis_tdata(md[0]), .m_axis_tlast(ml[0]), .m_axis_tvalid(mv[0]), .m_axis_tready(mr[0]),
    .full(full[0]), .empty(empty[0]), .almost_full(af[0]), .almost_empty(ae[0]),
    .data_count(dc[0]), .pkt_count(pc[0]));

  axis_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_MODE(1'b1)) u1 (
    .aclk(clk), .aresetn(aresetn), .wr_en(wr_en[1]), .re_en(re_en[1]),
    .s_axis_tdata(sd[1]), .s_axis_tlast(sl[1]), .s_axis_tvalid(sv[1]), .s_axis_tready(sr[1]),
    .m_axis_tdata(md[1]), .m_axis_tlast(ml[1]), .m_axis_tvalid(mv[1]), .m_axis_tready(mr[1]),
    .full(full[1]), .empty(empty[1]), .almost_full(af[1]), .almost_empty(ae[1]),
    .data_count(dc[1]), .pkt_count(pc[1]));

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0h expected %0h at %0t", d, nm, act, exp, $time);
    end
  endtask

  // monitor: the model holds every word inside the fifo (memory plus output register) in order
  always @(negedge clk) begin
    int n, edc;
    bit ldo, rel;
    logic [DW:0] e;
    for (int d = 0; d < 2; d++) begin
      if (!aresetn) begin
        q[d].delete();
        plast[d] = 0;
        acc[d] = 0;
        p_mv[d] = 0;
        p_hs[d] = 0;
        p_ld[d] = 0;
        p_stall[d] = 0;
      end else begin
        n = q[d].size();
        edc = n - int'(mv[d]);
        ldo = mv[d] && (!p_mv[d] || p_hs[d]);
        chk(d, "load", ldo, p_ld[d]);
        chk(d, "data_count", dc[d], edc);
        chk(d, "pkt_count", pc[d], plast[d]);
        chk(d, "empty", empty[d], n == 0);
        chk(d, "full", full[d], edc == DEPTH);
        chk(d, "almost_full", af[d], edc >= AF);
        chk(d, "almost_empty", ae[d], edc <= AE);
        if (p_stall[d]) chk(d, "hold", {mv[d], ml[d], md[d]}, {1'b1, p_out[d]});
        rel = d == 0 || plast[d] > 0 || edc == DEPTH;
        p_ld[d] = edc != 0 && re_en[d] && (!mv[d] || mr[d]) && rel;
        p_mv[d] = mv[d];
        p_hs[d] = mv[d] && mr[d];
        p_stall[d] = mv[d] && !mr[d];
        p_out[d] = {ml[d], md[d]};
        if (mv[d] && mr[d]) begin
          hs_cnt[d]++;
          if (q[d].size() == 0) chk(d, "out_unexpected", {ml[d], md[d]}, 'x);
          else begin
            e = q[d].pop_front();
            chk(d, "out_word", {ml[d], md[d]}, e);
            if (e[DW]) plast[d]--;
          end
        end
        acc[d] = sv[d] && sr[d];
        if (acc[d]) begin
          q[d].push_back({sl[d], sd[d]});
          if (sl[d]) plast[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [DW-1:0] data, input logic last);
    int n;
    sv[d] = 1'b1;
    sd[d] = data;
    sl[d] = last;
    n = 0;
    @(negedge clk);
    while (!(sv[d] && sr[d]) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) chk(d, "send_timeout", n, 0);
    tick();
    sv[d] = 1'b0;
    sl[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    re_en[d] = 1'b1;
    mr[d] = 1'b1;
    sv[d] = 1'b0;
    n = 0;
    while (!empty[d] && n < BOUND) begin
      tick();
      n++;
    end
    chk(d, "drain_empty", empty[d], 1'b1);
    chk(d, "drain_model", q[d].size(), 0);
  endtask

  task automatic reset_checks(input int d);
    chk(d, "rst_full", full[d], 1'b0);
    chk(d, "rst_empty", empty[d], 1'b1);
    chk(d, "rst_almost_full", af[d], 1'b0);
    chk(d, "rst_almost_empty", ae[d], 1'b1);
    chk(d, "rst_mvalid", mv[d], 1'b0);
    chk(d, "rst_mdata", {ml[d], md[d]}, 0);
    chk(d, "rst_sready", sr[d], 1'b1);
    chk(d, "rst_data_count", dc[d], 0);
    chk(d, "rst_pkt_count", pc[d], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w;
    int base;
    aresetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 1'b1;
      re_en[d] = 1'b1;
      sv[d] = 1'b0;
      sl[d] = 1'b0;
      sd[d] = '0;
      mr[d] = 1'b1;
      hs_cnt[d] = 0;
    end
    #12;
    for (int d = 0; d < 2; d++) reset_checks(d);
    tick();
    aresetn = 1'b1;
    tick();
    sv[0] = 1'b1;
    sd[0] = 8'hA5;
    tick();
    sv[0] = 1'b0;
    chk(0, "lat_not_yet", mv[0], 1'b0);
    tick();
    chk(0, "lat_valid", mv[0], 1'b1);
    chk(0, "lat_data", md[0], 8'hA5);
    tick();
    tick();
    base = hs_cnt[0];
    sv[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sd[0] = DW'(i * 7 + 3);
      tick();
    end
    sv[0] = 1'b0;
    chk(0, "burst_rate", hs_cnt[0] - base, 198);
    tick();
    tick();
    chk(0, "burst_total", hs_cnt[0] - base, 200);
    chk(0, "burst_empty", empty[0], 1'b1);
    re_en[0] = 1'b0;
    sv[0] = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      sd[0] = DW'($urandom);
      tick();
      if (i == 16) chk(0, "ae_at_16", ae[0], 1'b1);
      if (i == 17) chk(0, "ae_at_17", ae[0], 1'b0);
      if (i == AF - 1) chk(0, "af_below", af[0], 1'b0);
      if (i == AF) chk(0, "af_at", af[0], 1'b1);
    end
    chk(0, "fill_full", full[0], 1'b1);
    chk(0, "fill_sready", sr[0], 1'b0);
    w = DW'($urandom);
    sd[0] = w;
    repeat (3) tick();
    chk(0, "fill_hold_count", dc[0], DEPTH);
    chk(0, "fill_mvalid", mv[0], 1'b0);
    re_en[0] = 1'b1;
    send(0, w, 1'b0);
    drain(0);
    mr[0] = 1'b0;
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b1);
    tick();
    chk(0, "bp_valid", mv[0], 1'b1);
    chk(0, "bp_first", md[0], 8'h11);
    repeat (10) tick();
    chk(0, "bp_stall_data", {ml[0], md[0]}, {1'b0, 8'h11});
    re_en[0] = 1'b0;
    repeat (2) tick();
    chk(0, "bp_reen_low_valid", mv[0], 1'b1);
    mr[0] = 1'b1;
    tick();
    mr[0] = 1'b0;
    chk(0, "bp_valid_clear", mv[0], 1'b0);
    chk(0, "bp_count", dc[0], 2);
    drain(0);
    for (int i = 0; i < 6; i++) send(1, DW'(8'h40 + i), 1'b0);
    repeat (3) tick();
    chk(1, "pkt_gate_valid", mv[1], 1'b0);
    chk(1, "pkt_gate_count", pc[1], 0);
    sv[1] = 1'b1;
    sd[1] = 8'h46;
    sl[1] = 1'b1;
    tick();
    sv[1] = 1'b0;
    sl[1] = 1'b0;
    chk(1, "pkt_count_one", pc[1], 1);
    chk(1, "pkt_not_yet", mv[1], 1'b0);
    tick();
    chk(1, "pkt_valid", mv[1], 1'b1);
    chk(1, "pkt_first", md[1], 8'h40);
    drain(1);
    chk(1, "pkt_count_zero", pc[1], 0);
    sv[1] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sd[1] = DW'($urandom);
      tick();
    end
    sv[1] = 1'b0;
    chk(1, "big_full", full[1], 1'b1);
    chk(1, "big_not_yet", mv[1], 1'b0);
    tick();
    chk(1, "big_release", mv[1], 1'b1);
    for (int i = 0; i < 50; i++) send(1, DW'($urandom), 1'b0);
    send(1, 8'hEE, 1'b1);
    drain(1);
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!sv[d] || acc[d]) begin
          sv[d] = $urandom_range(0, 3) != 0;
          sd[d] = DW'($urandom);
          sl[d] = $urandom_range(0, 7) == 0;
        end
        wr_en[d] = $urandom_range(0, 7) != 0;
        re_en[d] = $urandom_range(0, 5) != 0;
        mr[d] = c < 1500 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      end
      tick();
    end
    wr_en[0] = 1'b1;
    wr_en[1] = 1'b1;
    sv[0] = 1'b0;
    send(1, 8'h5A, 1'b1);
    drain(0);
    drain(1);
    re_en[0] = 1'b0;
    sv[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sd[0] = DW'($urandom);
      sl[0] = i % 10 == 9;
      tick();
    end
    chk(0, "mid_count_pre", dc[0], 100);
    chk(0, "mid_pkt_pre", pc[0], 10);
    aresetn = 1'b0;
    #2;
    reset_checks(0);
    reset_checks(1);
    sv[0] = 1'b0;
    sl[0] = 1'b0;
    tick();
    aresetn = 1'b1;
    repeat (3) tick();
    chk(0, "post_rst_empty", empty[0], 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Parametrised AXI4-Stream FIFO with configurable data width and depth, optional packet (store-and-forward) mode, occupancy and packet counters, and programmable almost-full/almost-empty flags. It is the generalised successor to the fixed 8-bit, 4096-deep AXIS FIFO. It sits between an AXIS producer and consumer in the same `aclk` domain. It keeps the `wr_en`/`re_en` gating used across the codebase, and its master output is fully AXIS-compliant: valid is never withdrawn without a handshake.

## Interface
- `DATA_WIDTH`, default 8: tdata width in bits.
- `ADDR_WIDTH`, default 12: memory depth DEPTH = 2**ADDR_WIDTH words (4096).
- `PACKET_MODE`, default 0: 1 = release data only once a complete packet (tlast) is stored.
- `AF_THRESH`, default DEPTH-16: almost_full asserts when data_count >= AF_THRESH.
- `AE_THRESH`, default 16: almost_empty asserts when data_count <= AE_THRESH.

Ports (clock and reset first):
- `aclk` in 1: single clock; all logic on the rising edge.
- `aresetn` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: write gate; accepts from the slave port only when high.
- `re_en` in 1: read gate; the output stage refills only when high.
- `s_axis_tdata` in DATA_WIDTH: input data.
- `s_axis_tlast` in 1: input end of packet.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready = wr_en && !full (combinational).
- `m_axis_tdata` out DATA_WIDTH: output data (registered).
- `m_axis_tlast` out 1: output end of packet (registered).
- `m_axis_tvalid` out 1: output valid (registered).
- `m_axis_tready` in 1: output ready.
- `full` out 1: data_count == DEPTH.
- `empty` out 1: data_count == 0 && !m_axis_tvalid.
- `almost_full` out 1: data_count >= AF_THRESH.
- `almost_empty` out 1: data_count <= AE_THRESH.
- `data_count` out ADDR_WIDTH+1: words held in memory, excluding the output register.
- `pkt_count` out ADDR_WIDTH+1: complete packets whose tlast has not yet left the master port.

## Operation
- **Storage.** Dual-port RAM of DEPTH x (DATA_WIDTH+1) words, holding tdata and tlast. Write and read pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- **Write.** A write (wr) occurs when s_axis_tvalid && s_axis_tready. It stores {tlast, tdata} at the write pointer and increments the write pointer.
- **Output register.** A single output register holds m_axis_tdata, m_axis_tlast and m_axis_tvalid.
- **Output handshake.** An output handshake (hs) occurs when m_axis_tvalid && m_axis_tready.
- **Load.** A load occurs when data_count != 0 && re_en && (!m_axis_tvalid || hs) && release.
  - release = 1 when PACKET_MODE = 0.
  - release = (pkt_count != 0 || full) when PACKET_MODE = 1. The `full` term prevents deadlock on a packet longer than DEPTH.
  - A load copies the word at the read pointer into the output register, sets m_axis_tvalid and increments the read pointer.
- **Valid clear.** On hs without a load, m_axis_tvalid clears.
- **Output stability.** While m_axis_tvalid = 1 and hs has not occurred, m_axis_tdata/m_axis_tlast/m_axis_tvalid hold. This applies even if re_en falls.
- **data_count.** +1 on wr, -1 on load; unchanged when both occur in the same cycle.
- **pkt_count.** +1 on wr with s_axis_tlast, -1 on hs with m_axis_tlast; unchanged when both occur.
- **Full/empty boundaries.**
  - At full, s_axis_tready = 0. A load in the same cycle frees space only from the next cycle; there is no bypass.
  - When empty, a write never reaches the output in the same cycle.
- **Reset** (aresetn low, any time, asynchronous): pointers, data_count, pkt_count, m_axis_tvalid, m_axis_tlast and m_axis_tdata go to 0. RAM contents are don't-care. Any in-flight packet is discarded.
- **Reset values of outputs:** full=0, empty=1, almost_full=0, almost_empty=1, s_axis_tready=wr_en, m_axis_*=0.

## Timing
- **Latency.** A word written at edge k, into an empty FIFO with re_en=1, sets m_axis_tvalid after edge k+1. That is 1 cycle of latency.
- **Packet mode latency.** The tlast word written at edge k makes pkt_count=1 after edge k. The packet's first word is valid after edge k+1. Earlier words of that packet are not presented before this.
- **Throughput.** 1 word/cycle sustained on both ports. Load and hs occur on the same edge.
- **Flags.** full, empty, almost_* and the counters are registered or derived from registers. They update on the edge after the causing event.
- **Output stalls.** m_axis_tready low for N cycles holds the output for N cycles with no word loss.

## Test plan
- **Reset.** Assert aresetn=0 with wr_en=1 → full=0, empty=1, almost_empty=1, m_axis_tvalid=0, s_axis_tready=1, data_count=0, pkt_count=0. Repeat mid-burst after 100 writes → all counters 0 on the next sample.
- **Pass-through** (PACKET_MODE=0, defaults). Write 0xA5 at edge k with re_en=1 and m_axis_tready=1 → m_axis_tvalid=1 with data 0xA5 after edge k+1. Then a 200-word burst → 200 words out in order at 1/cycle.
- **Fill to full.** Write 4096 words with re_en=0 → full=1 and s_axis_tready=0 after the 4096th. almost_full=1 from data_count=4080. Word 4097 is held by the source and not lost.
- **Backpressure.** Hold m_axis_tready=0 for 10 cycles with valid=1 → tdata/tlast stable. Drop re_en while valid=1 → valid stays until hs.
- **Packet mode** (PACKET_MODE=1). Write 6 words without tlast → m_axis_tvalid stays 0. The 7th word with tlast at edge k → first word valid after edge k+1 and pkt_count=1. pkt_count returns to 0 after the tlast hs.
- **Oversize packet** (PACKET_MODE=1). Write 4096 words with no tlast → full=1 releases output. Streaming continues with no deadlock.
